sys_gpio_port: RTL
==================

# sys_gpio_port

Parametrised Avalon-MM general-purpose I/O port: per-bit output data with atomic set/clear, per-bit direction, synchronised input sampling, and optional per-bit rising/falling edge capture with a masked, level interrupt. It sits on the system interconnect as a zero-wait-state slave, one instance per GPIO bank, and drives pad output-enables directly.

## Interface
- `WIDTH`, 32: number of GPIO bits, 1..32; unused readdata bits read 0.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `RESET_OUT`, 0: reset value of the output data register (WIDTH bits).
- `RESET_DIR`, 0: reset value of the direction register (1 = output).

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `address` in 3: word offset.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data; bits above WIDTH ignored.
- `readdata` out 32: combinational read data.
- `gpio_in` in WIDTH: asynchronous pad inputs.
- `gpio_out` out WIDTH: output data register.
- `gpio_oe` out WIDTH: direction register (pad output-enable).
- `irq` out 1: registered, active-high interrupt.

## Operation
- Write strobe = `chipselect & ~write_n`; no read strobe, reads have no side effects.
- Address map: 0 DATA (read = synchronised `gpio_in`; write = load out register); 1 DIR (r/w); 2 IRQMASK (r/w); 3 EDGECAP (read captured bits; write-1-to-clear); 4 OUTSET (write ORs into out; read = out); 5 OUTCLR (write ANDs ~writedata; read = out); 6 RISE_EN (r/w); 7 FALL_EN (r/w).
- Reset values: out = RESET_OUT, dir = RESET_DIR, IRQMASK/EDGECAP/RISE_EN/FALL_EN = 0, synchroniser and previous-sample registers = 0, `irq` = 0.
- Edge detect per bit on synchroniser output `s` against its one-cycle delay `p`: rise = s & ~p & RISE_EN, fall = ~s & p & FALL_EN; any detected edge sets EDGECAP bit.
- Edge detection is independent of direction (output bits echoing back through pads still capture).
- Simultaneous EDGECAP clear-write and new edge on same bit, same cycle: bit stays set (no lost edge).
- `irq` = registered OR-reduce of (EDGECAP & IRQMASK).
- Reset during any activity: all registers return to reset values on that edge; pending edges discarded.

## Timing
- Writes: register and `gpio_out`/`gpio_oe` update on the clock edge with write strobe asserted; readdata reflects new value the following cycle.
- Reads: zero wait states, readdata valid combinationally in the cycle address is presented.
- Input path: pin stable before edge k -> DATA read shows it after edge k+SYNC_STAGES-1; EDGECAP bit set at edge k+SYNC_STAGES; `irq` high at edge k+SYNC_STAGES+1.
- EDGECAP clear at edge c -> `irq` low at edge c+1 (if no other masked bit set).
- IRQMASK change at edge m -> `irq` follows at edge m+1.

## Configuration
- `SYS_GPIO_EDGE_CAPTURE_EN` defined: edge detect, EDGECAP, IRQMASK, RISE_EN, FALL_EN, and `irq` as above.
- Undefined: those registers are not built; offsets 2,3,6,7 read 0 and ignore writes; `irq` tied 0; DATA/DIR/OUTSET/OUTCLR unchanged.

## Structure
- Package `sys_gpio_pkg`: address offset constants (ADDR_DATA..ADDR_FALL_EN), 3-bit address typedef.
- Sub-module `sys_gpio_sync`: WIDTH-wide, SYNC_STAGES-deep synchroniser with synchronous active-high reset to 0.
- Top holds register file, edge logic, read mux, irq register.

## Test plan
- Reset with RESET_OUT=0xA5, RESET_DIR=0x0F (WIDTH=8) -> `gpio_out`=0xA5, `gpio_oe`=0x0F, `irq`=0, reads of 2,3,6,7 = 0.
- Write 0x0F to DATA, 0xF0 to OUTSET, 0x3C to OUTCLR -> `gpio_out` 0x0F, 0xFF, 0xC3 on successive writes; reads at offset 4/5 return 0xC3.
- RISE_EN=0x01, IRQMASK=0x01, `gpio_in[0]` 0->1 before edge k -> EDGECAP=0x01 at k+2, `irq`=1 at k+3 (SYNC_STAGES=2); write 0x01 to EDGECAP -> `irq`=0 next cycle.
- FALL_EN=0x02, IRQMASK=0, `gpio_in[1]` 1->0 -> EDGECAP=0x02, `irq` stays 0; then IRQMASK=0x02 -> `irq`=1 one cycle later.
- Clear-write of EDGECAP bit 0 in same cycle a new rising edge on bit 0 is detected -> EDGECAP bit 0 remains 1, `irq` remains 1.
- Build without `SYS_GPIO_EDGE_CAPTURE_EN`, toggle inputs with writes to offsets 2,3,6,7 -> those offsets read 0, `irq` constant 0, DATA reads track pins after SYNC_STAGES cycles.

Source files
------------

// File: rtl/sys_gpio_pkg.sv
// Shared address map and address type for the sys_gpio_port GPIO bank.
package sys_gpio_pkg;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_DATA    = 3'd0;
    localparam addr_t ADDR_DIR     = 3'd1;
    localparam addr_t ADDR_IRQMASK = 3'd2;
    localparam addr_t ADDR_EDGECAP = 3'd3;
    localparam addr_t ADDR_OUTSET  = 3'd4;
    localparam addr_t ADDR_OUTCLR  = 3'd5;
    localparam addr_t ADDR_RISE_EN = 3'd6;
    localparam addr_t ADDR_FALL_EN = 3'd7;

endpackage

// File: rtl/sys_gpio_sync.sv
// Multi-stage flop synchroniser bringing asynchronous pad inputs into the clk domain.
module sys_gpio_sync
    import sys_gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/sys_gpio_port.sv
// Avalon-MM GPIO bank: output data with atomic set/clear, direction, synchronised inputs.
// Define SYS_GPIO_EDGE_CAPTURE_EN to build edge capture, IRQMASK/RISE_EN/FALL_EN and irq.
module sys_gpio_port
    import sys_gpio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  addr_t            address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rd_val;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    // Bits above WIDTH are deliberately dropped.
    assign unused_wdata = ^writedata;

    sys_gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_in),
        .q     (sync_in)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= RESET_OUT;
            dir_q <= RESET_DIR;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   out_q <= wdata;
                ADDR_DIR:    dir_q <= wdata;
                ADDR_OUTSET: out_q <= out_q | wdata;
                ADDR_OUTCLR: out_q <= out_q & ~wdata;
                default: ;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

`ifdef SYS_GPIO_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] cap_clr;
    logic             irq_q;

    // A new edge wins over a same-cycle clear so no edge is ever lost.
    always_comb begin
        edges   = (sync_in & ~prev_q & rise_q) | (~sync_in & prev_q & fall_q);
        cap_clr = (wr_en && address == ADDR_EDGECAP) ? wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync_in;
            cap_q  <= (cap_q & ~cap_clr) | edges;
            irq_q  <= |(cap_q & mask_q);
            if (wr_en) begin
                case (address)
                    ADDR_IRQMASK: mask_q <= wdata;
                    ADDR_RISE_EN: rise_q <= wdata;
                    ADDR_FALL_EN: fall_q <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:   rd_val = sync_in;
            ADDR_DIR:    rd_val = dir_q;
            ADDR_OUTSET: rd_val = out_q;
            ADDR_OUTCLR: rd_val = out_q;
`ifdef SYS_GPIO_EDGE_CAPTURE_EN
            ADDR_IRQMASK: rd_val = mask_q;
            ADDR_EDGECAP: rd_val = cap_q;
            ADDR_RISE_EN: rd_val = rise_q;
            ADDR_FALL_EN: rd_val = fall_q;
`endif
            default:     rd_val = '0;
        endcase
        readdata = '0;
        readdata[WIDTH-1:0] = rd_val;
    end

endmodule
